// File: rtl/spi_pkg.sv
// Shared SPI types: mode encoding, CPOL/CPHA helpers and the responder state enum.

package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } slave_state_t;

  function automatic logic cpol(input logic [1:0] mode);
    spi_mode_t m;
    m = spi_mode_t'(mode);
    return m.cpol;
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    spi_mode_t m;
    m = spi_mode_t'(mode);
    return m.cpha;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input, with a selectable reset value.

module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI responder oversampling sclk/ss_n/mosi in the clk domain, MSB-first, buffered tx.
// Optional status outputs (tx_underrun, rx_overrun, rx_ack input) under `SPI_SLAVE_STATUS_EN.

module spi_slave
  import spi_pkg::*;
#(
  parameter logic [1:0] SPI_MODE   = 2'd0,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic                  rx_ack,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
`endif
  output logic                  rx_valid
);

  localparam logic CPOL_L = cpol(SPI_MODE);
  localparam logic CPHA_L = cpha(SPI_MODE);
  localparam int   CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  // Handshake: tx word moves into the buffer on a clk where tx_valid && tx_ready;
  // rx_valid is a single-clk pulse with no back-pressure, rx_data holds until the next word.

  logic sclk_s, ss_n_s, mosi_s, sclk_d;

  spi_sync #(.RST_VAL(CPOL_L)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b1))   u_sync_ss_n (.clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_n_s));
  spi_sync #(.RST_VAL(1'b0))   u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_d <= CPOL_L;
    else        sclk_d <= sclk_s;
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = CPOL_L ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL_L ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA_L ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_L ? lead_edge : trail_edge;

  slave_state_t           state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-2:0]  rx_sr;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic                   tx_full;

  logic                  last_bit, rx_done, word_start, tx_accept;
  logic [DATA_WIDTH-1:0] load_word, rx_word;

  assign last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign rx_done    = (state == S_ACTIVE) && !ss_n_s && sample_edge && last_bit;
  assign word_start = ((state == S_IDLE) && !ss_n_s) || rx_done;
  assign tx_accept  = tx_valid && !tx_full;
  assign load_word  = tx_full ? tx_buf : '0;
  assign rx_word    = {rx_sr, mosi_s};

  assign tx_ready = ~tx_full;
  assign miso_oe  = (state == S_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // A word accepted alongside a word start lands after the transfer.
      if (tx_accept) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (word_start) begin
        tx_full <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
          if (!ss_n_s) begin
            state <= S_ACTIVE;
            if (CPHA_L) begin
              tx_sr <= load_word;
            end else begin
              miso  <= load_word[DATA_WIDTH-1];
              tx_sr <= {load_word[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        S_ACTIVE: begin
          if (ss_n_s) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            miso    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
          end else begin
            if (shift_edge) begin
              miso  <= tx_sr[DATA_WIDTH-1];
              tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx_sr <= rx_word[DATA_WIDTH-2:0];
              if (last_bit) begin
                bit_cnt  <= '0;
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
                // Next word's MSB goes out on the following shift edge.
                tx_sr    <= load_word;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_pending  <= 1'b0;
    end else begin
      tx_underrun <= word_start && !tx_full;
      rx_overrun  <= rx_done && rx_pending && !rx_ack;
      rx_pending  <= rx_done || (rx_pending && !rx_ack);
    end
  end
`endif

endmodule
